// File: rtl/hamming_bitpair_encoder_pkg.sv
// Shared channel-coding definitions for the extended-Hamming (8,4) bit-pair link.
// The encode function is also used by the decoder's checker model.
package hamming_bitpair_encoder_pkg;

  localparam int CW_W  = 8;
  localparam int NIB_W = 4;
  localparam int PAIRS = 4;

  typedef enum logic {
    ST_IDLE,
    ST_SEND
  } enc_state_e;

  // Bit layout mirrors the decoder's syndrome equations: data in c[4:1], checks in c[7:5].
  function automatic logic [CW_W-1:0] hamming84_encode(input logic [NIB_W-1:0] nibble,
                                                       input logic             overall_parity_en);
    logic [CW_W-1:0] c;
    c      = '0;
    c[4:1] = nibble;
    c[5]   = nibble[0] ^ nibble[2] ^ nibble[3];
    c[6]   = nibble[0] ^ nibble[1] ^ nibble[2];
    c[7]   = nibble[1] ^ nibble[2] ^ nibble[3];
    c[0]   = overall_parity_en ? ^c[7:1] : 1'b0;
    return c;
  endfunction

endpackage

// File: rtl/hamming_bitpair_encoder_encode_comb.sv
// Combinational nibble-to-codeword stage of the bit-pair encoder.
module hamming84_encode_comb
  import hamming_bitpair_encoder_pkg::*;
#(
  parameter bit OVERALL_PARITY = 1'b1
) (
  input  logic [NIB_W-1:0] nibble,
  output logic [CW_W-1:0]  codeword
);

  assign codeword = hamming84_encode(nibble, OVERALL_PARITY);

endmodule

// File: rtl/hamming_bitpair_encoder.sv
// Serial payload to extended-Hamming codeword encoder, emitting each codeword as four
// (x, y) bit pairs. A one-deep pending register absorbs a flush that lands mid-codeword.
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_IDLE | no codeword in flight, outputs low
// ST_SEND | presenting pair pair_q of tx_q; pair 0 carries sync
module hamming_bitpair_encoder
  import hamming_bitpair_encoder_pkg::*;
#(
  parameter bit OVERALL_PARITY = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_bit,
  input  logic       in_valid,
  input  logic       in_last,
  output logic       in_ready,
  input  logic       inj_en,
  input  logic [2:0] inj_pos,
  output logic       out_x,
  output logic       out_y,
  output logic       out_valid,
  output logic       sync
);

  logic [NIB_W-1:0] nib_q;
  logic [NIB_W-1:0] nib_full;
  logic [1:0]       fill_q;
  logic [CW_W-1:0]  cw_enc;
  logic [CW_W-1:0]  inj_mask;
  logic [CW_W-1:0]  cw_inj;
  logic [CW_W-1:0]  tx_q;
  logic [CW_W-1:0]  pend_q;
  logic             pend_full_q;
  enc_state_e       state_q, state_d;
  logic [1:0]       pair_q, pair_d;
  logic             accept;
  logic             complete;
  logic             load_new;
  logic             load_pend;
  logic             store_pend;

  assign in_ready = !pend_full_q;
  assign accept   = in_valid && in_ready;

  // Nibble as it stands including this cycle's bit; unfilled positions stay zero (padding).
  always_comb begin
    nib_full = nib_q;
    if (accept) nib_full[fill_q] = in_bit;
  end

  assign complete = (accept && (fill_q == 2'd3)) ||
                    (in_last && in_ready && ((fill_q != 2'd0) || in_valid));

  hamming84_encode_comb #(
    .OVERALL_PARITY(OVERALL_PARITY)
  ) u_encode (
    .nibble  (nib_full),
    .codeword(cw_enc)
  );

  always_comb begin
    inj_mask = '0;
    if (inj_en) inj_mask[inj_pos] = 1'b1;
  end

  assign cw_inj = cw_enc ^ inj_mask;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      nib_q  <= '0;
      fill_q <= 2'd0;
    end else if (complete) begin
      nib_q  <= '0;
      fill_q <= 2'd0;
    end else if (accept) begin
      nib_q  <= nib_full;
      fill_q <= fill_q + 2'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      pair_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      pair_q  <= pair_d;
    end
  end

  // Completion while pending is full cannot occur: in_ready is low then.
  always_comb begin
    state_d    = state_q;
    pair_d     = pair_q;
    load_new   = 1'b0;
    load_pend  = 1'b0;
    store_pend = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (complete) begin
          state_d  = ST_SEND;
          pair_d   = 2'd0;
          load_new = 1'b1;
        end
      end
      ST_SEND: begin
        if (pair_q == 2'(PAIRS - 1)) begin
          pair_d = 2'd0;
          if (complete)         load_new  = 1'b1;
          else if (pend_full_q) load_pend = 1'b1;
          else                  state_d   = ST_IDLE;
        end else begin
          pair_d     = pair_q + 2'd1;
          store_pend = complete;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_q        <= '0;
      pend_q      <= '0;
      pend_full_q <= 1'b0;
    end else begin
      if (load_new)       tx_q <= cw_inj;
      else if (load_pend) tx_q <= pend_q;
      if (store_pend) begin
        pend_q      <= cw_inj;
        pend_full_q <= 1'b1;
      end else if (load_pend) begin
        pend_full_q <= 1'b0;
      end
    end
  end

  assign out_valid = (state_q == ST_SEND);
  assign sync      = out_valid && (pair_q == 2'd0);
  assign out_x     = out_valid && tx_q[{pair_q, 1'b0}];
  assign out_y     = out_valid && tx_q[{pair_q, 1'b1}];

endmodule

// File: tb/tb_hamming_bitpair_encoder.sv
// Directed bench for hamming_bitpair_encoder: hand-computed codewords, pair order,
// sync/valid timing, flush padding, error injection, pending collision and async reset.
module tb_hamming_bitpair_encoder;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_bit, in_valid, in_last, inj_en;
  logic [2:0] inj_pos;
  logic       in_ready, out_x, out_y, out_valid, sync;
  logic       np_ready, np_x, np_y, np_valid, np_sync;

  hamming_bitpair_encoder dut (
    .clk(clk), .reset(reset), .in_bit(in_bit), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready), .inj_en(inj_en), .inj_pos(inj_pos), .out_x(out_x), .out_y(out_y),
    .out_valid(out_valid), .sync(sync)
  );

  hamming_bitpair_encoder #(.OVERALL_PARITY(1'b0)) dut_np (
    .clk(clk), .reset(reset), .in_bit(in_bit), .in_valid(in_valid), .in_last(in_last),
    .in_ready(np_ready), .inj_en(inj_en), .inj_pos(inj_pos), .out_x(np_x), .out_y(np_y),
    .out_valid(np_valid), .sync(np_sync)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [7:0] words[$];
  logic [7:0] words_np[$];
  logic [7:0] acc, acc_np;
  int pos, nvalid, nsync, cyc, first_v, last_v;

  task automatic clear_stats();
    words.delete();
    words_np.delete();
    acc = '0; acc_np = '0;
    pos = 0; nvalid = 0; nsync = 0; cyc = 0; first_v = -1; last_v = -1;
  endtask

  // One clock; then sample the output stream and rebuild codewords from sync-aligned pairs.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (out_valid) begin
      nvalid++;
      if (first_v < 0) first_v = cyc;
      last_v = cyc;
      if (sync) begin
        nsync++;
        pos = 0;
      end else begin
        pos++;
      end
      if (pos < 4) begin
        acc[2*pos]      = out_x;
        acc[2*pos+1]    = out_y;
        acc_np[2*pos]   = np_x;
        acc_np[2*pos+1] = np_y;
      end
      if (pos == 3) begin
        words.push_back(acc);
        words_np.push_back(acc_np);
      end
    end
  endtask

  task automatic drive(input logic v, input logic b, input logic l);
    in_valid = v;
    in_bit   = b;
    in_last  = l;
    step();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0);
  endtask

  task automatic nibble_1011();
    drive(1'b1, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 1'b0);
  endtask

  logic [7:0] rx;
  logic [2:0] syn;

  initial begin
    reset = 1'b1; in_bit = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    inj_en = 1'b0; inj_pos = 3'd0;
    #12;
    check("rst_valid", out_valid, 1'b0);
    check("rst_sync",  sync,      1'b0);
    check("rst_xy",    {out_x, out_y}, 2'b00);
    check("rst_ready", in_ready,  1'b1);
    @(posedge clk); #1 reset = 1'b0;

    // Nibble 1,0,1,1 -> 8'h3A, pairs (0,1),(0,1),(1,1),(0,0)
    clear_stats();
    nibble_1011();
    check("t1_sync_pair0", sync, 1'b1);
    check("t1_xy_pair0", {out_x, out_y}, 2'b01);
    idle(6);
    check("t1_nwords", words.size(), 1);
    if (words.size() > 0) check("t1_cw", words[0], 8'h3A);
    check("t1_nvalid", nvalid, 4);
    check("t1_nsync", nsync, 1);
    check("t1_latency", first_v, 4);

    // 0000 then 1111 back to back
    clear_stats();
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_bit   = (i >= 4);
      in_last  = 1'b0;
      check($sformatf("t2_ready_%0d", i), in_ready, 1'b1);
      step();
    end
    idle(6);
    check("t2_nwords", words.size(), 2);
    if (words.size() > 1) begin
      check("t2_cw0", words[0], 8'h00);
      check("t2_cw1", words[1], 8'hFF);
    end
    check("t2_nvalid", nvalid, 8);
    check("t2_gapless", last_v - first_v + 1, 8);
    check("t2_nsync", nsync, 2);

    // Single bit then in_last alone -> padded 1000
    clear_stats();
    drive(1'b1, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b1);
    idle(6);
    check("t3_nwords", words.size(), 1);
    if (words.size() > 0) check("t3_cw_par", words[0], 8'h63);
    if (words_np.size() > 0) check("t3_cw_nopar", words_np[0], 8'h62);
    check("t3_nvalid", nvalid, 4);

    // in_last with nothing collected is ignored
    clear_stats();
    drive(1'b0, 1'b0, 1'b1);
    idle(6);
    check("t3b_empty_last", nvalid, 0);

    // Injection sampled only on the completion cycle
    clear_stats();
    inj_en = 1'b1; inj_pos = 3'd0;
    drive(1'b1, 1'b1, 1'b0);
    inj_en = 1'b0;
    drive(1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0);
    inj_en = 1'b1; inj_pos = 3'd3;
    drive(1'b1, 1'b1, 1'b0);
    inj_en = 1'b0; inj_pos = 3'd0;
    idle(6);
    check("t4_nwords", words.size(), 1);
    rx = (words.size() > 0) ? words[0] : 8'h00;
    check("t4_cw", rx, 8'h32);
    // Decoder-side view: syndrome from the three check equations, correct, extract data
    syn = {rx[7] ^ rx[2] ^ rx[3] ^ rx[4], rx[6] ^ rx[1] ^ rx[2] ^ rx[3], rx[5] ^ rx[1] ^ rx[3] ^ rx[4]};
    case (syn)
      3'b011: rx[1] = ~rx[1];
      3'b110: rx[2] = ~rx[2];
      3'b111: rx[3] = ~rx[3];
      3'b101: rx[4] = ~rx[4];
      default: ;
    endcase
    check("t4_decoded", rx[4:1], 4'b1101);

    // Collision: flush lands while pair 1 is in flight
    clear_stats();
    nibble_1011();
    drive(1'b1, 1'b1, 1'b0);
    in_valid = 1'b0; in_bit = 1'b0; in_last = 1'b1;
    check("t5_ready_before", in_ready, 1'b1);
    step();
    check("t5_ready_pair2", in_ready, 1'b0);
    drive(1'b1, 1'b1, 1'b1);
    check("t5_ready_pair3", in_ready, 1'b0);
    drive(1'b1, 1'b1, 1'b0);
    check("t5_ready_after", in_ready, 1'b1);
    check("t5_sync_pend", sync, 1'b1);
    idle(8);
    check("t5_nwords", words.size(), 2);
    if (words.size() > 1) begin
      check("t5_cw0", words[0], 8'h3A);
      check("t5_cw1", words[1], 8'h63);
    end
    check("t5_nvalid", nvalid, 8);
    check("t5_gapless", last_v - first_v + 1, 8);

    // Reset during pair 2 with a partial nibble held
    clear_stats();
    nibble_1011();
    drive(1'b1, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 1'b0);
    check("t6_pre_xy", {out_x, out_y}, 2'b11);
    in_valid = 1'b0; in_bit = 1'b0;
    reset = 1'b1;
    #1;
    check("t6_async_valid", out_valid, 1'b0);
    check("t6_async_xy", {out_x, out_y}, 2'b00);
    check("t6_async_sync", sync, 1'b0);
    check("t6_async_ready", in_ready, 1'b1);
    @(posedge clk); #1 reset = 1'b0;
    clear_stats();
    nibble_1011();
    idle(6);
    check("t6_nwords", words.size(), 1);
    if (words.size() > 0) check("t6_cw", words[0], 8'h3A);
    check("t6_nsync", nsync, 1);
    check("t6_nvalid", nvalid, 4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
